mem_store_unit: RTL and testbench

//  MEM-stage store path: the write-side counterpart of the ID immediate extender and load extenders.
//  - Narrows a 32-bit rt value into byte-lane data plus a write strobe for SB/SH/SW/SWL/SWR.
//  - Issues the write on the SRAM-like data bus (req/addr_ok/data_ok).
//  - Stalls the pipeline until the write is acknowledged; flags an address error (AdES) on misaligned stores.

---
 rtl/mem_store_unit_pkg.sv | 30 +++
 rtl/mem_store_unit_packer.sv | 77 +++++++
 rtl/mem_store_unit.sv | 111 +++++++++++
 tb/tb_mem_store_unit.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_store_unit_pkg.sv
// Shared definitions for the MEM-stage store path: store opcode encodings,
// data-bus size codes, FSM state type and the packed bus request record.
package mem_store_unit_pkg;

   localparam int ST_ADDR_W = 32;

   localparam logic [2:0] STOREOP_SB  = 3'd0;
   localparam logic [2:0] STOREOP_SH  = 3'd1;
   localparam logic [2:0] STOREOP_SW  = 3'd2;
   localparam logic [2:0] STOREOP_SWL = 3'd3;
   localparam logic [2:0] STOREOP_SWR = 3'd4;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } st_state_e;

   typedef struct packed {
      logic [ST_ADDR_W-1:0] addr;
      logic [1:0]           size;
      logic [3:0]           wstrb;
      logic [31:0]          wdata;
   } store_req_t;

endpackage

// File: rtl/mem_store_unit_packer.sv
// Combinational store packer: turns (op, effective address, rt value) into a
// lane-aligned bus request and flags misalignment.
//   op     in   3-bit store opcode
//   addr   in   effective address
//   data   in   rt register value
//   req    out  packed request (addr, size, wstrb, wdata)
//   ades   out  store is misaligned for its size (only meaningful when op_ok)
//   op_ok  out  op is a recognised store opcode
module mem_store_unit_packer
   import mem_store_unit_pkg::*;
(
   input  logic [2:0]           op,
   input  logic [ST_ADDR_W-1:0] addr,
   input  logic [31:0]          data,
   output store_req_t           req,
   output logic                 ades,
   output logic                 op_ok
);

   logic [1:0]           a;
   logic [ST_ADDR_W-1:0] addr_word;

   assign a         = addr[1:0];
   assign addr_word = {addr[ST_ADDR_W-1:2], 2'b00};

   always_comb begin
      req   = '0;
      ades  = 1'b0;
      op_ok = 1'b1;
      case (op)
         STOREOP_SB: begin
            req.addr  = addr;
            req.size  = SZ_BYTE;
            req.wstrb = 4'b0001 << a;
            req.wdata = {4{data[7:0]}};
         end
         STOREOP_SH: begin
            req.addr  = addr;
            req.size  = SZ_HALF;
            req.wstrb = a[1] ? 4'b1100 : 4'b0011;
            req.wdata = {2{data[15:0]}};
            ades      = a[0];
         end
         STOREOP_SW: begin
            req.addr  = addr;
            req.size  = SZ_WORD;
            req.wstrb = 4'b1111;
            req.wdata = data;
            ades      = |a;
         end
         // SWL writes the high-order bytes of rt into the low lanes up to a.
         STOREOP_SWL: begin
            req.addr = addr_word;
            req.size = SZ_WORD;
            case (a)
               2'd0:    begin req.wstrb = 4'b0001; req.wdata = {24'b0, data[31:24]}; end
               2'd1:    begin req.wstrb = 4'b0011; req.wdata = {16'b0, data[31:16]}; end
               2'd2:    begin req.wstrb = 4'b0111; req.wdata = {8'b0,  data[31:8]};  end
               default: begin req.wstrb = 4'b1111; req.wdata = data;                 end
            endcase
         end
         // SWR writes the low-order bytes of rt into lanes a and above.
         STOREOP_SWR: begin
            req.addr = addr_word;
            req.size = SZ_WORD;
            case (a)
               2'd0:    begin req.wstrb = 4'b1111; req.wdata = data;                 end
               2'd1:    begin req.wstrb = 4'b1110; req.wdata = {data[23:0], 8'b0};  end
               2'd2:    begin req.wstrb = 4'b1100; req.wdata = {data[15:0], 16'b0}; end
               default: begin req.wstrb = 4'b1000; req.wdata = {data[7:0], 24'b0};  end
            endcase
         end
         default: op_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store unit: packs a store, issues it on the SRAM-like data bus
// and stalls the pipeline until the write is acknowledged.
//   clk, resetn                 clock, async active-low reset
//   st_valid/op/addr/data       store presented by the MEM stage
//   flush                       blocks a new issue (never cancels an issued one)
//   st_stall                    hold MEM and upstream
//   st_done                     1-cycle pulse on write acknowledge
//   st_ades/st_badvaddr         misaligned store report (combinational)
//   data_sram_*                 request channel / addr_ok / data_ok responses
//
// state   | meaning
// IDLE    | no store outstanding; may issue
// REQ     | req=1, waiting for addr_ok
// WAIT    | address accepted, waiting for data_ok
module mem_store_unit
   import mem_store_unit_pkg::*;
#(
   parameter int ADDR_W = ST_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              st_valid,
   input  logic [2:0]        st_op,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic              flush,
   output logic              st_stall,
   output logic              st_done,
   output logic              st_ades,
   output logic [ADDR_W-1:0] st_badvaddr,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [3:0]        data_sram_wstrb,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok
);

   st_state_e  state_q, state_d;
   store_req_t req_q, req_d;

   store_req_t pack_req;
   logic       pack_ades;
   logic       pack_op_ok;
   logic       issue;
   logic       done;

   mem_store_unit_packer u_packer (
      .op    (st_op),
      .addr  (st_addr),
      .data  (st_data),
      .req   (pack_req),
      .ades  (pack_ades),
      .op_ok (pack_op_ok)
   );

   assign issue = (state_q == ST_IDLE) & st_valid & pack_op_ok & ~pack_ades & ~flush;
   assign done  = ((state_q == ST_REQ) & data_sram_addr_ok & data_sram_data_ok) |
                  ((state_q == ST_WAIT) & data_sram_data_ok);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               state_d = ST_REQ;
               req_d   = pack_req;
            end
         end
         ST_REQ: begin
            if (data_sram_addr_ok) begin
               state_d = data_sram_data_ok ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (data_sram_data_ok) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      st_ades         = st_valid & pack_op_ok & pack_ades;
      st_badvaddr     = st_ades ? st_addr : '0;
      st_done         = done;
      st_stall        = issue | ((state_q != ST_IDLE) & ~done);
      data_sram_req   = (state_q == ST_REQ);
      data_sram_wr    = (state_q == ST_REQ);
      data_sram_size  = req_q.size;
      data_sram_addr  = req_q.addr;
      data_sram_wstrb = req_q.wstrb;
      data_sram_wdata = req_q.wdata;
   end

endmodule

// File: tb/tb_mem_store_unit.sv
module tb_mem_store_unit;
   import mem_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        st_valid;
   logic [2:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic        flush;
   logic        st_stall, st_done, st_ades;
   logic [31:0] st_badvaddr;
   logic        data_sram_req, data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [31:0] data_sram_addr;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok, data_sram_data_ok;

   always #5 clk = ~clk;

   mem_store_unit dut (
      .clk               (clk),
      .resetn            (resetn),
      .st_valid          (st_valid),
      .st_op             (st_op),
      .st_addr           (st_addr),
      .st_data           (st_data),
      .flush             (flush),
      .st_stall          (st_stall),
      .st_done           (st_done),
      .st_ades           (st_ades),
      .st_badvaddr       (st_badvaddr),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_addr    (data_sram_addr),
      .data_sram_wstrb   (data_sram_wstrb),
      .data_sram_wdata   (data_sram_wdata),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok)
   );

   typedef struct {
      logic [31:0] addr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   addr_lat = 0;
   int   data_lat = 1;
   int   done_cnt = 0;
   time  last_issue_t = 0;

   bit   hs_armed = 0;
   bit   dpend = 0;
   int   acnt = 0;
   int   dcnt = 0;

   always @(posedge clk) if (st_done === 1'b1) done_cnt++;

   // Bus responder and scoreboard: every REQ cycle the presented request is
   // compared with the oldest expected one, which is retired on the handshake.
   initial begin
      data_sram_addr_ok = 1'b0;
      data_sram_data_ok = 1'b0;
      forever begin
         @(negedge clk);
         if (hs_armed && resetn) begin
            dpend = 1;
            dcnt  = data_lat - 1;
            if (sb.size() > 0) void'(sb.pop_front());
         end
         hs_armed = 0;
         data_sram_addr_ok = 1'b0;
         data_sram_data_ok = 1'b0;
         if (!resetn) begin
            acnt  = 0;
            dpend = 0;
         end else begin
            if (dpend) begin
               if (dcnt <= 0) begin
                  data_sram_data_ok = 1'b1;
                  dpend = 0;
               end else dcnt--;
            end
            if (data_sram_req === 1'b1) begin
               n_total++;
               if (sb.size() == 0) begin
                  $display("FAIL sb_req: request addr=%h with no store expected", data_sram_addr);
               end else if (data_sram_addr !== sb[0].addr || data_sram_size !== sb[0].size ||
                            data_sram_wstrb !== sb[0].wstrb || data_sram_wdata !== sb[0].wdata ||
                            data_sram_wr !== 1'b1) begin
                  $display("FAIL sb_req: got addr=%h size=%0d wstrb=%b wdata=%h wr=%b, want addr=%h size=%0d wstrb=%b wdata=%h wr=1",
                           data_sram_addr, data_sram_size, data_sram_wstrb, data_sram_wdata, data_sram_wr,
                           sb[0].addr, sb[0].size, sb[0].wstrb, sb[0].wdata);
               end else n_pass++;
               if (acnt >= addr_lat) begin
                  data_sram_addr_ok = 1'b1;
                  hs_armed = 1;
                  acnt = 0;
               end else acnt++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic exp_t model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
      exp_t e;
      int a;
      logic [3:0] all1;
      a = int'(addr[1:0]);
      all1 = 4'hF;
      e.addr = addr; e.size = 2'd2; e.wstrb = 4'hF; e.wdata = d;
      case (op)
         STOREOP_SB: begin
            e.size = 2'd0; e.wstrb = 4'(1 << a); e.wdata = {24'b0, d[7:0]} * 32'h01010101;
         end
         STOREOP_SH: begin
            e.size = 2'd1; e.wstrb = 4'(3 << a); e.wdata = {16'b0, d[15:0]} * 32'h00010001;
         end
         STOREOP_SWL: begin
            e.addr = addr & ~32'h3; e.wstrb = all1 >> (3 - a); e.wdata = d >> (8 * (3 - a));
         end
         STOREOP_SWR: begin
            e.addr = addr & ~32'h3; e.wstrb = 4'(15 << a); e.wdata = d << (8 * a);
         end
         default: ;
      endcase
      return e;
   endfunction

   function automatic exp_t mk(input logic [31:0] a, input logic [1:0] s, input logic [3:0] w, input logic [31:0] d);
      exp_t e;
      e.addr = a; e.size = s; e.wstrb = w; e.wdata = d;
      return e;
   endfunction

   task automatic run_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d,
                            input exp_t e, input string name, input bit flush_in_req,
                            output int lat_req, output int lat_done);
      int n;
      bit stall_bad;
      @(negedge clk); #1;
      st_valid = 1'b1; st_op = op; st_addr = addr; st_data = d;
      sb.push_back(e);
      last_issue_t = $time;
      #1;
      n_total++;
      if (st_stall !== 1'b1 || data_sram_req !== 1'b0)
         $display("FAIL %s_issue: stall=%b req=%b, want stall=1 req=0", name, st_stall, data_sram_req);
      else n_pass++;
      n = 0; lat_req = -1; lat_done = -1; stall_bad = 0;
      while (n < 100) begin
         @(negedge clk); #1; n++;
         if (data_sram_req === 1'b1 && lat_req < 0) begin
            lat_req = n;
            if (flush_in_req) flush = 1'b1;
         end
         if (st_done === 1'b1) begin
            lat_done = n;
            break;
         end
         if (st_stall !== 1'b1) stall_bad = 1;
      end
      n_total++;
      if (lat_done < 0 || stall_bad || st_stall !== 1'b0)
         $display("FAIL %s_done: lat_done=%0d stall_low_early=%0d stall_at_done=%b, want done seen, stall 1 until done then 0",
                  name, lat_done, stall_bad, st_stall);
      else n_pass++;
      @(posedge clk); #1;
      st_valid = 1'b0;
      flush = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; st_valid = 1'b0; st_op = 3'd0; st_addr = '0; st_data = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if ({data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
           st_stall, st_done, st_ades, st_badvaddr} !== '0)
         $display("FAIL reset_outputs: req=%b wr=%b size=%0d addr=%h wstrb=%b wdata=%h stall=%b done=%b ades=%b, want all 0",
                  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr, data_sram_wstrb, data_sram_wdata,
                  st_stall, st_done, st_ades);
      else n_pass++;
      resetn = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if (data_sram_req !== 1'b0 || st_stall !== 1'b0)
         $display("FAIL reset_idle: req=%b stall=%b, want 0 0", data_sram_req, st_stall);
      else n_pass++;
   endtask

   task automatic test_sb();
      int lr, ld, d0;
      d0 = done_cnt;
      run_store(STOREOP_SB, 32'h1003, 32'h123456AB, mk(32'h1003, 2'd0, 4'b1000, 32'hABABABAB), "sb", 0, lr, ld);
      n_total++;
      if (lr != 1 || ld != 2) $display("FAIL sb_latency: req at %0d done at %0d, want 1 and 2", lr, ld);
      else n_pass++;
      n_total++;
      if (done_cnt - d0 != 1) $display("FAIL sb_done_count: %0d pulses, want 1", done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_ades();
      bit req_seen;
      @(negedge clk); #1;
      st_valid = 1'b1; st_op = STOREOP_SH; st_addr = 32'h1001; st_data = 32'h5555AAAA;
      #1;
      n_total++;
      if (st_ades !== 1'b1 || st_badvaddr !== 32'h1001 || st_stall !== 1'b0)
         $display("FAIL ades_sh: ades=%b badvaddr=%h stall=%b, want 1 00001001 0", st_ades, st_badvaddr, st_stall);
      else n_pass++;
      req_seen = 0;
      repeat (3) begin @(negedge clk); #1; if (data_sram_req !== 1'b0) req_seen = 1; end
      n_total++;
      if (req_seen) $display("FAIL ades_no_req: req seen for misaligned SH, want none");
      else n_pass++;
      st_op = STOREOP_SW; st_addr = 32'h1002; flush = 1'b1;
      #1;
      n_total++;
      if (st_ades !== 1'b1 || st_badvaddr !== 32'h1002)
         $display("FAIL ades_sw_flush: ades=%b badvaddr=%h, want 1 00001002", st_ades, st_badvaddr);
      else n_pass++;
      st_op = STOREOP_SB; st_addr = 32'h1003;
      #1;
      n_total++;
      if (st_ades !== 1'b0 || st_badvaddr !== 32'h0)
         $display("FAIL ades_sb_none: ades=%b badvaddr=%h, want 0 0", st_ades, st_badvaddr);
      else n_pass++;
      flush = 1'b0;
      for (int op = 5; op < 8; op++) begin
         st_op = 3'(op); st_addr = 32'h1001;
         #1;
         n_total++;
         if (st_ades !== 1'b0 || st_stall !== 1'b0)
            $display("FAIL unknown_op%0d: ades=%b stall=%b, want 0 0", op, st_ades, st_stall);
         else n_pass++;
         @(negedge clk); #1;
         n_total++;
         if (data_sram_req !== 1'b0) $display("FAIL unknown_op%0d_req: req=%b, want 0", op, data_sram_req);
         else n_pass++;
      end
      st_valid = 1'b0;
   endtask

   task automatic test_swl_swr();
      int lr, ld;
      run_store(STOREOP_SWL, 32'h2002, 32'hAABBCCDD, mk(32'h2000, 2'd2, 4'b0111, 32'h00AABBCC), "swl", 0, lr, ld);
      run_store(STOREOP_SWR, 32'h2001, 32'hAABBCCDD, mk(32'h2000, 2'd2, 4'b1110, 32'hBBCCDD00), "swr", 0, lr, ld);
      n_total++;
      if (ld != 2) $display("FAIL swr_latency: done at %0d, want 2", ld);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      int lr, ld, d0;
      d0 = done_cnt;
      addr_lat = 3; data_lat = 2;
      run_store(STOREOP_SW, 32'h3000, 32'hDEADBEEF, mk(32'h3000, 2'd2, 4'b1111, 32'hDEADBEEF), "sw_wait", 0, lr, ld);
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if (lr != 1 || ld != 6 || done_cnt - d0 != 1)
         $display("FAIL sw_wait_timing: req at %0d done at %0d pulses %0d, want 1 6 1", lr, ld, done_cnt - d0);
      else n_pass++;
      addr_lat = 0; data_lat = 1;
   endtask

   task automatic test_flush();
      int lr, ld;
      bit bad;
      addr_lat = 2;
      run_store(STOREOP_SH, 32'h3102, 32'h0000BEEF, mk(32'h3102, 2'd1, 4'b1100, 32'hBEEFBEEF), "flush_req", 1, lr, ld);
      n_total++;
      if (ld != 4) $display("FAIL flush_req_timing: done at %0d, want 4", ld);
      else n_pass++;
      addr_lat = 0;
      @(negedge clk); #1;
      st_valid = 1'b1; st_op = STOREOP_SW; st_addr = 32'h3200; st_data = 32'h11112222; flush = 1'b1;
      bad = 0;
      #1;
      if (st_stall !== 1'b0) bad = 1;
      repeat (3) begin @(negedge clk); #1; if (data_sram_req !== 1'b0 || st_stall !== 1'b0) bad = 1; end
      n_total++;
      if (bad) $display("FAIL flush_idle: req or stall asserted while flushed, want both 0");
      else n_pass++;
      st_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      int n, lr, ld, d0;
      data_lat = 20;
      d0 = done_cnt;
      @(negedge clk); #1;
      st_valid = 1'b1; st_op = STOREOP_SW; st_addr = 32'h5000; st_data = 32'hCAFEF00D;
      sb.push_back(mk(32'h5000, 2'd2, 4'b1111, 32'hCAFEF00D));
      n = 0;
      do begin @(negedge clk); #1; n++; end while (data_sram_req !== 1'b1 && n < 20);
      @(negedge clk); #1;
      n_total++;
      if (data_sram_req !== 1'b0 || st_stall !== 1'b1)
         $display("FAIL rst_mid_wait: req=%b stall=%b, want 0 1 in WAIT", data_sram_req, st_stall);
      else n_pass++;
      resetn = 1'b0; st_valid = 1'b0;
      #1;
      n_total++;
      if (data_sram_req !== 1'b0 || st_stall !== 1'b0 || st_done !== 1'b0)
         $display("FAIL rst_mid_async: req=%b stall=%b done=%b, want 0 0 0", data_sram_req, st_stall, st_done);
      else n_pass++;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      data_lat = 1;
      n_total++;
      if (done_cnt != d0) $display("FAIL rst_mid_no_done: %0d pulses, want 0", done_cnt - d0);
      else n_pass++;
      run_store(STOREOP_SB, 32'h5001, 32'h000000C3, mk(32'h5001, 2'd0, 4'b0010, 32'hC3C3C3C3), "rst_after", 0, lr, ld);
      n_total++;
      if (lr != 1 || ld != 2) $display("FAIL rst_after_timing: req at %0d done at %0d, want 1 2", lr, ld);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int lr, ld;
      time t0;
      run_store(STOREOP_SB, 32'h6000, 32'h00000011, mk(32'h6000, 2'd0, 4'b0001, 32'h11111111), "b2b_a", 0, lr, ld);
      t0 = last_issue_t;
      run_store(STOREOP_SH, 32'h6002, 32'h00002233, mk(32'h6002, 2'd1, 4'b1100, 32'h22332233), "b2b_b", 0, lr, ld);
      n_total++;
      if (last_issue_t - t0 != 30 || lr != 1 || ld != 2)
         $display("FAIL b2b_rate: issue spacing %0t req %0d done %0d, want 30 1 2", last_issue_t - t0, lr, ld);
      else n_pass++;
   endtask

   task automatic test_random();
      int lr, ld;
      logic [2:0]  op;
      logic [31:0] addr, d;
      for (int i = 0; i < 10; i++) begin
         op = 3'($urandom_range(0, 4));
         addr = 32'h8000 + ($urandom_range(0, 255) << 2);
         if (op == STOREOP_SH) addr = addr + ($urandom_range(0, 1) << 1);
         else if (op != STOREOP_SW) addr = addr + $urandom_range(0, 3);
         d = $urandom;
         addr_lat = $urandom_range(0, 2);
         data_lat = $urandom_range(1, 3);
         run_store(op, addr, d, model(op, addr, d), "rand", 0, lr, ld);
         n_total++;
         if (ld != 1 + addr_lat + data_lat)
            $display("FAIL rand_latency: op=%0d done at %0d, want %0d", op, ld, 1 + addr_lat + data_lat);
         else n_pass++;
      end
      addr_lat = 0; data_lat = 1;
   endtask

   initial begin
      test_reset();
      test_sb();
      test_ades();
      test_swl_swr();
      test_wait_states();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      repeat (3) @(negedge clk);
      n_total++;
      if (sb.size() != 0) $display("FAIL sb_drained: %0d requests never issued, want 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
